wb_retire_unit: RTL and testbench
=================================

# wb_retire_unit

Multi-lane write-back and retire stage: commits up to NLANES in-order results per cycle into the architectural register file and keeps 64-bit retire and clock counters. It also raises a sticky run-stop flag at a programmable instruction count and feeds a buffered retire trace to a debug consumer over valid/ready. It sits at the tail of the pipeline, after memory, and drives `regfile` back to decode/forwarding.

## Interface
- XLEN, 32, data/address width
- NLANES, 2, retire lanes per cycle; lane 0 is oldest in program order
- TRACE_DEPTH, 8, trace FIFO entries; power of two, at least NLANES
- INIT_SP, 32'h00007500, reset value of x2
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- valid  in  NLANES  lane retires this cycle
- pc  in  NLANES×XLEN  retiring PC per lane
- inst_id  in  NLANES×IId  instruction id per lane
- rf_wen  in  NLANES  lane writes a register
- reg_addr  in  NLANES×5  destination register
- wdata  in  NLANES×XLEN  write data
- stop_at  in  64  retire count at which to stop; 0 disables
- regfile  out  32×XLEN  architectural registers
- inst_count  out  64  retired instructions
- clock_count  out  64  cycles since reset
- stop  out  1  sticky stop flag
- trace_valid  out  1  trace head valid
- trace_ready  in  1  consumer accepts head
- trace_pc / trace_inst_id / trace_wen / trace_reg_addr / trace_wdata  out  XLEN / IId / 1 / 5 / XLEN  head entry fields
- trace_drops  out  32  saturating count of dropped trace entries

## Operation
- Reset (rst_n low at a clk edge): regfile[0]=0, regfile[2]=INIT_SP, all other registers all-ones. inst_count=0, clock_count=0, stop=0, FIFO empty, trace_valid=0, trace_drops=0. Reset mid-operation discards all FIFO contents and in-flight retirements that cycle.
- A lane is effective when valid[i] is set and stop is 0. While stop is 1, inputs are ignored: no writes, no counting, no trace. clock_count keeps running.
- Register write: for each effective lane with rf_wen and reg_addr≠0, regfile[reg_addr] <= wdata. When several lanes target the same register, the highest-index (youngest) lane wins. x0 is never written.
- inst_count += popcount(effective lanes); 64-bit wrap.
- stop: set when stop_at≠0 and the updated inst_count ≥ stop_at. Cleared only by reset.
- Trace push: effective lanes are enqueued in ascending lane order. The count check uses occupancy at the start of the cycle; a same-cycle pop is not credited. If free slots are fewer than the effective count, the whole cycle's group is dropped (all or nothing), and trace_drops += count, saturating at 2^32−1.
- Trace pop: the head is removed at a clk edge where trace_valid and trace_ready are both 1. The FIFO uses pointers of width log2(TRACE_DEPTH)+1 and wraps modulo depth. Full = pointers differ only in the MSB.

## Timing
- Register write, counters and stop update on the clk edge where the lane is presented. The new regfile value is visible in the following cycle; there is no internal bypass.
- stop is high in the cycle after the crossing retire. Lanes in that crossing cycle are committed.
- A trace entry is visible on trace_* no earlier than the cycle after its push. Head outputs hold stable while trace_valid=1 and trace_ready=0.
- An empty FIFO with push and no pop gives trace_valid=1 next cycle. A full FIFO with a pop and a 1-lane push drops the push, per the rule above.
- clock_count increments every cycle with rst_n high. The first cycle after reset release reads 0.

## Structure
- Package (basicparams): Addr, Inst, IId, UIntX, UInt5, IID_X, ADDR_MAX, and a packed `retire_trace_t` {pc, inst_id, wen, reg_addr, wdata}.
- One sub-module: `retire_trace_fifo`, a multi-push (≤NLANES) single-pop valid/ready FIFO of retire_trace_t with a free-slot count output.
- Top contains the regfile write merge, the counters and the stop logic.

## Test plan
- Reset: pulse rst_n low, then check regfile[2]=0x00007500, regfile[0]=0, regfile[5]=0xFFFFFFFF, inst_count=0, trace_valid=0.
- Same-register collision: lane0 writes x3=0x11 and lane1 writes x3=0x22 in one cycle → next cycle x3=0x22 and inst_count=2. A write of 0x55 to x0 leaves x0=0.
- Stop: stop_at=5 and retire 2 per cycle → stop=1 after the 3rd retiring cycle with inst_count=6. A further retire with x7 write leaves x7 and inst_count unchanged.
- Trace overflow: TRACE_DEPTH=8, trace_ready=0, 2 lanes per cycle for 5 cycles → 8 entries held, trace_drops=2. Draining yields PCs in lane/cycle order.
- Simultaneous push/pop at full with trace_ready=1: the 1-lane push is dropped (trace_drops+1), one entry pops, and occupancy is 7 next cycle.
- Mid-run reset with FIFO at 5 entries → next cycle trace_valid=0, counters 0 and regfile reinitialised.

Source files
------------

// File: rtl/basicparams.sv
// basicparams: shared widths, types and the retire trace record
package basicparams;
   localparam int XLEN = 32;
   localparam int IID_W = 8;
   typedef logic [XLEN-1:0]  Addr;
   typedef logic [31:0]      Inst;
   typedef logic [IID_W-1:0] IId;
   typedef logic [XLEN-1:0]  UIntX;
   typedef logic [4:0]       UInt5;
   localparam IId  IID_X    = '1;
   localparam Addr ADDR_MAX = '1;
   typedef struct packed {
      Addr  pc;
      IId   inst_id;
      logic wen;
      UInt5 reg_addr;
      UIntX wdata;
   } retire_trace_t;
endpackage

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: multi-push single-pop valid/ready FIFO of retire trace records
module retire_trace_fifo
   import basicparams::*;
#(
   parameter int DEPTH = 8,
   parameter int NPUSH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int PW = AW + 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NPUSH-1:0]          i_push,
   input  retire_trace_t [NPUSH-1:0] i_data,
   output logic [PW-1:0]             o_free,
   output logic                      o_valid,
   input  logic                      i_ready,
   output retire_trace_t             o_head
);
   retire_trace_t           r_mem [DEPTH];
   logic [PW-1:0]           r_wr, r_rd, w_used, w_cnt;
   logic [NPUSH-1:0][AW-1:0] w_idx;
   logic                    w_pop;
   assign w_used  = r_wr - r_rd;
   assign o_free  = PW'(DEPTH) - w_used;
   assign o_valid = w_used != '0;
   assign w_pop   = o_valid & i_ready;
   assign o_head  = r_mem[r_rd[AW-1:0]];
   // each pushing lane lands after the lower-index pushing lanes
   always_comb begin
      w_cnt = '0;
      w_idx = '0;
      for (int i = 0; i < NPUSH; i++) begin
         w_idx[i] = AW'(r_wr + w_cnt);
         w_cnt    = w_cnt + PW'(i_push[i]);
      end
   end
   // storage writes; contents are meaningless outside the pointer window
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NPUSH; i++)
         if (i_push[i]) r_mem[w_idx[i]] <= i_data[i];
   end
   // pointers carry one extra bit so full and empty are distinguishable
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         r_wr <= r_wr + w_cnt;
         if (w_pop) r_rd <= r_rd + 1'b1;
      end
   end
endmodule

// File: rtl/wb_retire_unit.sv
// wb_retire_unit: multi-lane write-back, retire counters, run-stop and retire trace
module wb_retire_unit
   import basicparams::*;
#(
   parameter int   NLANES      = 2,
   parameter int   TRACE_DEPTH = 8,
   parameter UIntX INIT_SP     = 32'h00007500
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic [NLANES-1:0]                 i_valid,
   input  logic [NLANES-1:0][XLEN-1:0]       i_pc,
   input  logic [NLANES-1:0][IID_W-1:0]      i_inst_id,
   input  logic [NLANES-1:0]                 i_rf_wen,
   input  logic [NLANES-1:0][4:0]            i_reg_addr,
   input  logic [NLANES-1:0][XLEN-1:0]       i_wdata,
   input  logic [63:0]                       i_stop_at,
   output logic [31:0][XLEN-1:0]             o_regfile,
   output logic [63:0]                       o_inst_count,
   output logic [63:0]                       o_clock_count,
   output logic                              o_stop,
   output logic                              o_trace_valid,
   input  logic                              i_trace_ready,
   output logic [XLEN-1:0]                   o_trace_pc,
   output logic [IID_W-1:0]                  o_trace_inst_id,
   output logic                              o_trace_wen,
   output logic [4:0]                        o_trace_reg_addr,
   output logic [XLEN-1:0]                   o_trace_wdata,
   output logic [31:0]                       o_trace_drops
);
   localparam int PW = $clog2(TRACE_DEPTH) + 1;
   logic [NLANES-1:0]         w_eff, w_push;
   logic [PW-1:0]             w_free, w_cnt;
   logic [63:0]               w_inst_next;
   logic                      w_accept;
   logic [32:0]               w_drop_sum;
   retire_trace_t [NLANES-1:0] w_entry;
   retire_trace_t             w_head;
   logic [31:0][XLEN-1:0]     r_rf;
   logic [63:0]               r_inst, r_clk;
   logic                      r_stop;
   logic [31:0]               r_drops;
   assign w_eff       = i_valid & {NLANES{~r_stop}};
   assign w_inst_next = r_inst + 64'(w_cnt);
   assign w_accept    = w_cnt <= w_free;
   assign w_push      = w_eff & {NLANES{w_accept}};
   assign w_drop_sum  = {1'b0, r_drops} + 33'(w_cnt);
   // count effective lanes and build their trace records
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < NLANES; i++) begin
         w_cnt      = w_cnt + PW'(w_eff[i]);
         w_entry[i] = {i_pc[i], i_inst_id[i], i_rf_wen[i], i_reg_addr[i], i_wdata[i]};
      end
   end
   // regfile merge: ascending lane order lets the youngest lane win a collision
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int r = 0; r < 32; r++) r_rf[r] <= (r == 2) ? INIT_SP : (r == 0) ? '0 : '1;
      end else begin
         for (int i = 0; i < NLANES; i++)
            if (w_eff[i] && i_rf_wen[i] && i_reg_addr[i] != '0) r_rf[i_reg_addr[i]] <= i_wdata[i];
      end
   end
   // retire/clock counters, sticky stop and saturating drop count
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_inst  <= '0;
         r_clk   <= '0;
         r_stop  <= 1'b0;
         r_drops <= '0;
      end else begin
         r_clk  <= r_clk + 64'd1;
         r_inst <= w_inst_next;
         if (i_stop_at != '0 && w_inst_next >= i_stop_at) r_stop <= 1'b1;
         if (!w_accept) r_drops <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
      end
   end
   retire_trace_fifo #(.DEPTH(TRACE_DEPTH), .NPUSH(NLANES)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_data  (w_entry),
      .o_free  (w_free),
      .o_valid (o_trace_valid),
      .i_ready (i_trace_ready),
      .o_head  (w_head)
   );
   assign o_regfile        = r_rf;
   assign o_inst_count     = r_inst;
   assign o_clock_count    = r_clk;
   assign o_stop           = r_stop;
   assign o_trace_drops    = r_drops;
   assign o_trace_pc       = w_head.pc;
   assign o_trace_inst_id  = w_head.inst_id;
   assign o_trace_wen      = w_head.wen;
   assign o_trace_reg_addr = w_head.reg_addr;
   assign o_trace_wdata    = w_head.wdata;
endmodule

// File: tb/tb_wb_retire_unit.sv
// tb_wb_retire_unit: directed and random checks of wb_retire_unit against a queue-based model
module tb_wb_retire_unit;
   localparam int DEPTH = 8;
   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        valid, rf_wen;
   logic [1:0][31:0]  pc, wdata;
   logic [1:0][7:0]   inst_id;
   logic [1:0][4:0]   reg_addr;
   logic [63:0]       stop_at;
   logic [31:0][31:0] regfile;
   logic [63:0]       inst_count, clock_count;
   logic              stop, trace_valid, trace_ready, trace_wen;
   logic [31:0]       trace_pc, trace_wdata, trace_drops;
   logic [7:0]        trace_inst_id;
   logic [4:0]        trace_reg_addr;
   int                checks = 0;
   int                failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  id;
      logic        wen;
      logic [4:0]  ra;
      logic [31:0] wd;
   } ent_t;
   logic [31:0]     m_rf [32];
   longint unsigned m_inst, m_clk;
   bit              m_stop;
   longint unsigned m_drops;
   ent_t            m_q[$];

   wb_retire_unit #(.NLANES(2), .TRACE_DEPTH(DEPTH), .INIT_SP(32'h00007500)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pc(pc), .i_inst_id(inst_id),
      .i_rf_wen(rf_wen), .i_reg_addr(reg_addr), .i_wdata(wdata), .i_stop_at(stop_at),
      .o_regfile(regfile), .o_inst_count(inst_count), .o_clock_count(clock_count),
      .o_stop(stop), .o_trace_valid(trace_valid), .i_trace_ready(trace_ready),
      .o_trace_pc(trace_pc), .o_trace_inst_id(trace_inst_id), .o_trace_wen(trace_wen),
      .o_trace_reg_addr(trace_reg_addr), .o_trace_wdata(trace_wdata), .o_trace_drops(trace_drops)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int   n;
      int   free;
      ent_t e;
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) m_rf[r] = (r == 0) ? 32'h0 : (r == 2) ? 32'h00007500 : 32'hFFFFFFFF;
         m_inst = 0; m_clk = 0; m_stop = 0; m_drops = 0;
         m_q.delete();
         return;
      end
      m_clk++;
      free = DEPTH - m_q.size();
      if (m_q.size() > 0 && trace_ready) void'(m_q.pop_front());
      if (!m_stop) begin
         n = 0;
         for (int l = 0; l < 2; l++)
            if (valid[l]) begin
               n++;
               if (rf_wen[l] && reg_addr[l] != 0) m_rf[reg_addr[l]] = wdata[l];
            end
         if (n <= free) begin
            for (int l = 0; l < 2; l++)
               if (valid[l]) begin
                  e.pc = pc[l]; e.id = inst_id[l]; e.wen = rf_wen[l]; e.ra = reg_addr[l]; e.wd = wdata[l];
                  m_q.push_back(e);
               end
         end else begin
            m_drops = (m_drops + n > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_drops + n;
         end
         m_inst += n;
         if (stop_at != 0 && m_inst >= stop_at) m_stop = 1;
      end
   endtask

   task automatic check_all();
      chk("inst_count", inst_count, m_inst);
      chk("clock_count", clock_count, m_clk);
      chk("stop", {63'd0, stop}, {63'd0, m_stop});
      chk("trace_drops", {32'd0, trace_drops}, m_drops);
      chk("trace_valid", {63'd0, trace_valid}, {63'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
         chk("trace_pc", {32'd0, trace_pc}, {32'd0, m_q[0].pc});
         chk("trace_inst_id", {56'd0, trace_inst_id}, {56'd0, m_q[0].id});
         chk("trace_wen", {63'd0, trace_wen}, {63'd0, m_q[0].wen});
         chk("trace_reg_addr", {59'd0, trace_reg_addr}, {59'd0, m_q[0].ra});
         chk("trace_wdata", {32'd0, trace_wdata}, {32'd0, m_q[0].wd});
      end
      for (int r = 0; r < 32; r++) chk($sformatf("x%0d", r), {32'd0, regfile[r]}, {32'd0, m_rf[r]});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic lane(input int l, input bit v, input logic [31:0] p, input logic [7:0] id,
                       input bit w, input logic [4:0] ra, input logic [31:0] wd);
      valid[l] = v; pc[l] = p; inst_id[l] = id; rf_wen[l] = w; reg_addr[l] = ra; wdata[l] = wd;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic push_pairs(input int cycles, input logic [31:0] base);
      for (int k = 0; k < cycles; k++) begin
         lane(0, 1, base + 32'(8 * k), 8'(2 * k), 0, 0, 0);
         lane(1, 1, base + 32'(8 * k + 4), 8'(2 * k + 1), 0, 0, 0);
         step();
      end
      valid = '0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; valid = '0; rf_wen = '0; pc = '0; inst_id = '0; reg_addr = '0; wdata = '0;
      stop_at = '0; trace_ready = 1'b0;
      step();
      step();
      chk("rst_x2", {32'd0, regfile[2]}, 64'h00007500);
      chk("rst_x0", {32'd0, regfile[0]}, 64'h0);
      chk("rst_x5", {32'd0, regfile[5]}, 64'hFFFFFFFF);
      chk("rst_inst", inst_count, 64'd0);
      chk("rst_clock", clock_count, 64'd0);
      chk("rst_tvalid", {63'd0, trace_valid}, 64'd0);
      rst_n = 1'b1;

      lane(0, 1, 32'h100, 8'd1, 1, 5'd3, 32'h11);
      lane(1, 1, 32'h104, 8'd2, 1, 5'd3, 32'h22);
      step();
      chk("collide_x3", {32'd0, regfile[3]}, 64'h22);
      chk("collide_inst", inst_count, 64'd2);
      chk("push_tvalid", {63'd0, trace_valid}, 64'd1);
      lane(0, 1, 32'h108, 8'd3, 1, 5'd0, 32'h55);
      lane(1, 0, 32'h0, 8'd0, 0, 5'd0, 32'h0);
      step();
      chk("x0_write", {32'd0, regfile[0]}, 64'h0);

      do_reset();
      stop_at = 64'd5;
      trace_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lane(0, 1, 32'h200 + 32'(8 * k), 8'(k), 0, 0, 0);
         lane(1, 1, 32'h204 + 32'(8 * k), 8'(k), 0, 0, 0);
         step();
         chk($sformatf("stop_c%0d", k), {63'd0, stop}, {63'd0, k == 2});
      end
      chk("stop_inst", inst_count, 64'd6);
      lane(0, 1, 32'h300, 8'd9, 1, 5'd7, 32'hAB);
      lane(1, 0, 32'h0, 8'd0, 0, 5'd0, 32'h0);
      step();
      chk("stop_x7", {32'd0, regfile[7]}, 64'hFFFFFFFF);
      chk("stop_inst_hold", inst_count, 64'd6);
      stop_at = '0;

      do_reset();
      trace_ready = 1'b0;
      push_pairs(5, 32'h1000);
      chk("ovf_drops", {32'd0, trace_drops}, 64'd2);
      trace_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("drain_pc%0d", j), {32'd0, trace_pc}, {32'd0, 32'h1000 + 32'(4 * j)});
         step();
      end
      chk("drain_empty", {63'd0, trace_valid}, 64'd0);

      trace_ready = 1'b0;
      push_pairs(4, 32'h2000);
      trace_ready = 1'b1;
      lane(0, 1, 32'h3000, 8'd7, 0, 0, 0);
      step();
      valid = '0;
      chk("full_pp_drops", {32'd0, trace_drops}, 64'd3);
      n = 0;
      while (trace_valid && n < 20) begin
         step();
         n++;
      end
      chk("full_pp_occ", 64'(n), 64'd7);

      trace_ready = 1'b0;
      push_pairs(2, 32'h4000);
      lane(0, 1, 32'h4010, 8'd4, 1, 5'd9, 32'h99);
      step();
      valid = '0;
      do_reset();
      chk("midrst_tvalid", {63'd0, trace_valid}, 64'd0);
      chk("midrst_inst", inst_count, 64'd0);
      chk("midrst_x9", {32'd0, regfile[9]}, 64'hFFFFFFFF);

      for (int t = 0; t < 400; t++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         if (!rst_n) stop_at = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(1, 300));
         for (int l = 0; l < 2; l++)
            lane(l, $urandom_range(0, 3) != 0, $urandom, 8'($urandom), $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom);
         trace_ready = $urandom_range(0, 2) == 0;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
